// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, Done DATA_WIDTH+2 cycles after accept.
// Divide-by-zero/overflow finish the cycle after accept; Ready is low while busy, so Valid is ignored then.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Valid,
  output logic                  Ready,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic [2:0]            MDControl,
  input  logic                  Flush,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] MDResult,
  output logic                  Zero
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic [W-1:0]         opb_q, opb_d;
  logic [W-1:0]         res_q, res_d;
  logic                 neg_q, neg_d;
  logic                 asgn_q, asgn_d;
  logic                 zero_q, zero_d;

  // Operand decode at accept: sign views, magnitudes and fast-path results.
  logic         a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic         div_zero, div_ovf, special;
  logic [W-1:0] special_res;
  logic         accept;

  assign a_signed = (MDControl != OP_MULHU) && (MDControl != OP_DIVU) && (MDControl != OP_REMU);
  assign b_signed = (MDControl == OP_MUL) || (MDControl == OP_MULH) ||
                    (MDControl == OP_DIV) || (MDControl == OP_REM);
  assign a_neg    = a_signed & SrcA[W-1];
  assign b_neg    = b_signed & SrcB[W-1];
  assign a_mag    = a_neg ? -SrcA : SrcA;
  assign b_mag    = b_neg ? -SrcB : SrcB;
  assign div_zero = (SrcB == '0);
  assign div_ovf  = ~MDControl[0] & (SrcA == MOST_NEG) & (&SrcB);
  assign special  = MDControl[2] & (div_zero | div_ovf);
  assign special_res = div_zero ? (MDControl[1] ? SrcA : '1)
                                : (MDControl[1] ? '0 : MOST_NEG);

  assign Ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign Done   = (state_q == S_DONE);
  assign accept = Valid & Ready & ~Flush;

  // One iteration: multiply shifts {hi,lo} right after a conditional add,
  // divide shifts the dividend into hi and retires one quotient bit into lo.
  logic [W:0]   mul_sum, div_shift;
  logic         div_ge;
  logic [W-1:0] div_diff, step_hi, step_lo;

  assign mul_sum   = {1'b0, hi_q} + ({1'b0, opb_q} & {(W+1){lo_q[0]}});
  assign div_shift = {hi_q, lo_q[W-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_diff  = div_shift[W-1:0] - opb_q;

  always_comb begin
    step_hi = '0;
    step_lo = '0;
    if (op_q[2]) begin
      step_hi = div_ge ? div_diff : div_shift[W-1:0];
      step_lo = {lo_q[W-2:0], div_ge};
    end else begin
      {step_hi, step_lo} = {mul_sum, lo_q[W-1:1]};
    end
  end

  // Final sign correction and result select.
  logic [2*W-1:0] prod_mag, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fix_res;

  assign prod_mag = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod_mag : prod_mag;
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = asgn_q ? -hi_q : hi_q;
  assign fix_res  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                            : ((op_q == OP_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    res_d   = res_q;
    neg_d   = neg_q;
    asgn_d  = asgn_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d   = MDControl;
          cnt_d  = '0;
          hi_d   = '0;
          neg_d  = a_neg ^ b_neg;
          asgn_d = a_neg;
          // Divide keeps the dividend in lo; multiply keeps the multiplier there.
          lo_d   = MDControl[2] ? a_mag : b_mag;
          opb_d  = MDControl[2] ? b_mag : a_mag;
          if (special) begin
            res_d   = special_res;
            zero_d  = (special_res == '0);
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d = step_hi;
          lo_d = step_lo;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      S_FIX: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          res_d   = fix_res;
          zero_d  = (fix_res == '0);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      asgn_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      asgn_q  <= asgn_d;
      zero_q  <= zero_d;
    end
  end

  assign MDResult = res_q;
  assign Zero     = zero_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative, parametrised multiply/divide execute unit. Covers the RV32M-style operations MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the single-cycle ALU in the execute stage. Operands are accepted with a valid/ready handshake; the result and a Zero flag are returned after a fixed, data-independent latency.
- Divide-by-zero and signed overflow take a short fast path.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and >= 4.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Valid  input  1  operands and MDControl valid this cycle.
- Ready  output  1  unit can accept an operation this cycle.
- SrcA  input  DATA_WIDTH  multiplicand / dividend.
- SrcB  input  DATA_WIDTH  multiplier / divisor.
- MDControl  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Flush  input  1  abort in-flight operation.
- Done  output  1  one-cycle pulse; Result valid.
- MDResult  output  DATA_WIDTH  registered result.
- Zero  output  1  registered, high when MDResult == 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Ready=1, Done=0, MDResult=0, Zero=1.
  - Internal accumulators and counter cleared.
  - Applies mid-operation with no Done.
- States:
  - IDLE: Ready=1. Valid=1 latches operands and MDControl.
    - If special case, go to DONE.
    - Otherwise go to CALC, counter=0.
  - CALC: one bit per cycle, DATA_WIDTH cycles; Ready=0. Counter reaching DATA_WIDTH-1 moves to FIX.
  - FIX: one cycle of sign correction and result select; writes MDResult and Zero; goes to DONE.
  - DONE: Done=1 for exactly one cycle; Ready=1.
    - Valid=1 here is accepted (back-to-back) and takes the IDLE accept path.
    - Otherwise go to IDLE.
- Latency, accept edge = edge where Valid&Ready is sampled high:
  - Normal: Done high in the cycle after DATA_WIDTH+1 further edges, i.e. DATA_WIDTH+2 cycles after accept (34 for W=32).
  - Special: Done high the cycle after accept.
- Valid while Ready=0 is ignored; operands are not re-sampled during CALC/FIX.
- Multiply:
  - Magnitude shift-add on |A|, |B|, producing a 2W-bit product.
  - MUL = low W bits.
  - MULH: signed x signed, high W bits.
  - MULHSU: signed A x unsigned B, high W bits.
  - MULHU: unsigned x unsigned, high W bits.
  - Negate the full 2W product in FIX when the operand signs differ (signed views only).
- Divide:
  - Restoring divide on magnitudes.
  - Quotient negated if signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
  - Unsigned ops use raw operands.
- Special cases, decided at accept:
  - SrcB==0: DIV/DIVU give all-ones; REM/REMU give SrcA.
  - Signed overflow, SrcA==most-negative and SrcB==-1: DIV gives most-negative; REM gives 0.
  - Multiply has no special cases.
- Flush:
  - In CALC or FIX: go to IDLE next edge, no Done; MDResult/Zero keep their previous values.
  - In IDLE or DONE: no effect, except that Valid in the same cycle is dropped.
- MDResult/Zero hold until the next FIX or special-case completion.

Test Plan:
- W=32, MUL 7 x 0xFFFFFFFD (-3) -> MDResult=0xFFFFFFEB, Done exactly 34 cycles after accept; Ready low cycles 1-33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with Done 1 cycle after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same -> 0 with Zero=1.
- Flush at cycle 10 of a MUL -> no Done, Ready=1 next cycle, MDResult unchanged. rst_n low mid-CALC -> immediate IDLE, MDResult=0, Zero=1.
- Valid pulsed during CALC ignored. Valid held in DONE cycle -> second op accepted; its Done follows 34 cycles later.
